decoded_bit_unloader: RTL and testbench

DECODED_BIT_UNLOADER -- requirements
Module: decoded_bit_unloader

---
 rtl/decoded_bit_unloader.sv | 131 +++++++++++++
 tb/tb_decoded_bit_unloader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decoded_bit_unloader.sv
// Captures a decoded frame of N hard bits while the decoder iterates, then
// streams it out as N/W words of W bits over a valid/ready handshake.
// Optional feature: define UNLOADER_CYCLE_COUNT_EN to add the Conv_Cycles
// output (Valid_Data cycles spent before the frame converged).
module decoded_bit_unloader #(
   parameter int unsigned N = 64,
   parameter int unsigned W = 8
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Valid_Data,
   input  logic [6:0]   Error_Count,
   input  logic [N-1:0] Hard_Bits,
   input  logic         Out_Ready,
   output logic         Out_Valid,
   output logic [W-1:0] Out_Data,
   output logic         Out_Last,
   output logic         Out_Converged,
   output logic         Busy,
`ifdef UNLOADER_CYCLE_COUNT_EN
   output logic [9:0]   Conv_Cycles,
`endif
   output logic         Overrun
);

   localparam int unsigned Words = N / W;
   localparam int unsigned KW    = (Words > 1) ? $clog2(Words) : 1;
   localparam logic [KW-1:0] KLast = KW'(Words - 1);

   typedef enum logic [1:0] {StIdle, StCollect, StStream} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  frame_q;
   logic          converged_q;
   logic [KW-1:0] k_q;
   logic          overrun_q;
   logic          vd_prev_q;
   logic          handshake;

   assign handshake = (state_q == StStream) && Out_Ready;

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (Valid_Data) state_d = StCollect;
         StCollect: if (!Valid_Data) state_d = StStream;
         StStream:  if (handshake && (k_q == KLast)) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Frame capture, word index and sticky overrun flag
   always_ff @(posedge Clock) begin
      if (Reset) begin
         frame_q     <= '0;
         converged_q <= 1'b0;
         k_q         <= '0;
         overrun_q   <= 1'b0;
         vd_prev_q   <= 1'b0;
      end else begin
         vd_prev_q <= Valid_Data;
         case (state_q)
            StIdle: begin
               if (Valid_Data) begin
                  frame_q     <= Hard_Bits;
                  converged_q <= (Error_Count == 7'd0);
               end
            end
            StCollect: begin
               // Once converged the frame is frozen; later errors are ignored
               if (Valid_Data && !converged_q) begin
                  frame_q     <= Hard_Bits;
                  converged_q <= (Error_Count == 7'd0);
               end
               if (!Valid_Data) begin
                  k_q <= '0;
               end
            end
            StStream: begin
               if (handshake) begin
                  k_q <= (k_q == KLast) ? '0 : k_q + KW'(1);
               end
               // A new decode starting mid-stream is dropped but remembered
               if (Valid_Data && !vd_prev_q) begin
                  overrun_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef UNLOADER_CYCLE_COUNT_EN
   logic [9:0] conv_cycles_q;

   // Count Valid_Data cycles preceding the one that converges, saturating
   always_ff @(posedge Clock) begin
      if (Reset) begin
         conv_cycles_q <= '0;
      end else if ((state_q == StIdle) && Valid_Data) begin
         conv_cycles_q <= (Error_Count == 7'd0) ? 10'd0 : 10'd1;
      end else if ((state_q == StCollect) && Valid_Data && !converged_q &&
                   (Error_Count != 7'd0) && (conv_cycles_q != 10'd1023)) begin
         conv_cycles_q <= conv_cycles_q + 10'd1;
      end
   end

   assign Conv_Cycles = conv_cycles_q;
`endif

   // Output decode from registered state
   always_comb begin
      Out_Valid     = (state_q == StStream);
      Out_Data      = Out_Valid ? frame_q[W*int'(k_q) +: W] : '0;
      Out_Last      = Out_Valid && (k_q == KLast);
      Out_Converged = converged_q;
      Busy          = (state_q != StIdle);
      Overrun       = overrun_q;
   end

endmodule

// File: tb/tb_decoded_bit_unloader.sv
// Randomized bench for decoded_bit_unloader with a frame-level reference model.
module tb_decoded_bit_unloader;
   localparam int unsigned N     = 64;
   localparam int unsigned W     = 8;
   localparam int          Words = N / W;

   logic         Clock = 1'b0;
   logic         Reset;
   logic         Valid_Data;
   logic [6:0]   Error_Count;
   logic [N-1:0] Hard_Bits;
   logic         Out_Ready;
   logic         Out_Valid;
   logic [W-1:0] Out_Data;
   logic         Out_Last;
   logic         Out_Converged;
   logic         Busy;
   logic         Overrun;
`ifdef UNLOADER_CYCLE_COUNT_EN
   logic [9:0]   Conv_Cycles;
`endif

   int   total = 0;
   int   bad   = 0;
   logic ov_exp;

   decoded_bit_unloader #(.N(N), .W(W)) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .Valid_Data    (Valid_Data),
      .Error_Count   (Error_Count),
      .Hard_Bits     (Hard_Bits),
      .Out_Ready     (Out_Ready),
      .Out_Valid     (Out_Valid),
      .Out_Data      (Out_Data),
      .Out_Last      (Out_Last),
      .Out_Converged (Out_Converged),
      .Busy          (Busy),
`ifdef UNLOADER_CYCLE_COUNT_EN
      .Conv_Cycles   (Conv_Cycles),
`endif
      .Overrun       (Overrun)
   );

   always #5 Clock = ~Clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ready_mode: 0 always ready, 1 pattern 1,0,0,... , 2 random.
   // ov_word/rst_word: word index at which to pulse Valid_Data / assert Reset (-1 none).
   task automatic run_frame(input int n, input int conv_idx, input int fix_idx,
                            input logic [63:0] fix_val, input int ready_mode,
                            input int ov_word, input int rst_word);
      logic [63:0] hard_q[$];
      int          ec_q[$];
      logic [63:0] hb;
      logic [6:0]  ec;
      logic [63:0] frame;
      logic        conv;
      int          first;
      int          k;
      int          cyc;
      bit          pulsing;
      bit          pulsed;
      bit          done;

      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         if (i > 0) begin
            check_val("collect_busy", Busy, 1);
            check_val("collect_valid", Out_Valid, 0);
         end
         hb = {$urandom, $urandom};
         if (i == fix_idx) hb = fix_val;
         if (i == conv_idx) ec = 7'd0;
         else if (conv_idx >= 0 && i > conv_idx) ec = 7'($urandom_range(127, 0));
         else ec = 7'($urandom_range(127, 1));
         Valid_Data  = 1'b1;
         Hard_Bits   = hb;
         Error_Count = ec;
         hard_q.push_back(hb);
         ec_q.push_back(int'(ec));
      end
      @(negedge Clock);
      check_val("collect_busy_end", Busy, 1);
      Valid_Data  = 1'b0;
      Hard_Bits   = {$urandom, $urandom};
      Error_Count = 7'($urandom);

      // Frame freezes at the first error-free iteration, else the last one wins
      first = -1;
      foreach (ec_q[i]) if (first < 0 && ec_q[i] == 0) first = i;
      conv  = (first >= 0);
      frame = conv ? hard_q[first] : hard_q[n-1];

      k       = 0;
      cyc     = 0;
      pulsing = 0;
      pulsed  = 0;
      done    = 0;
      while (!done && cyc < 200) begin
         @(negedge Clock);
         check_val("out_valid", Out_Valid, 1);
         check_val("out_data", Out_Data, 64'(8'(frame >> (W * k))));
         check_val("out_last", Out_Last, (k == Words - 1));
         check_val("out_converged", Out_Converged, conv);
         check_val("busy", Busy, 1);
         check_val("overrun", Overrun, ov_exp);
`ifdef UNLOADER_CYCLE_COUNT_EN
         check_val("conv_cycles", Conv_Cycles, conv ? first : ((n > 1023) ? 1023 : n));
`endif
         if (k == rst_word) begin
            Reset     = 1'b1;
            Out_Ready = 1'b1;
            @(negedge Clock);
            check_val("rst_out_valid", Out_Valid, 0);
            check_val("rst_busy", Busy, 0);
            check_val("rst_overrun", Overrun, 0);
            check_val("rst_out_data", Out_Data, 0);
            check_val("rst_out_last", Out_Last, 0);
            check_val("rst_out_converged", Out_Converged, 0);
            Reset     = 1'b0;
            Out_Ready = 1'b0;
            ov_exp    = 1'b0;
            return;
         end
         Hard_Bits   = {$urandom, $urandom};
         Error_Count = 7'($urandom);
         if (pulsing) begin
            Valid_Data = 1'b0;
            pulsing    = 0;
         end else if (k == ov_word && !pulsed) begin
            Valid_Data = 1'b1;
            pulsing    = 1;
            pulsed     = 1;
            ov_exp     = 1'b1;
         end
         case (ready_mode)
            0:       Out_Ready = 1'b1;
            1:       Out_Ready = (cyc % 3 == 0);
            default: Out_Ready = 1'($urandom_range(1, 0));
         endcase
         if (Out_Ready) k++;
         if (k == Words) done = 1;
         cyc++;
      end
      check_val("stream_done", done, 1);
      @(negedge Clock);
      Out_Ready = 1'b0;
      check_val("end_out_valid", Out_Valid, 0);
      check_val("end_busy", Busy, 0);
      check_val("end_overrun", Overrun, ov_exp);
   endtask

   initial begin
      int n;
      int c;
      Reset       = 1'b1;
      Valid_Data  = 1'b0;
      Error_Count = '0;
      Hard_Bits   = '0;
      Out_Ready   = 1'b0;
      ov_exp      = 1'b0;
      repeat (2) @(negedge Clock);
      check_val("reset_out_valid", Out_Valid, 0);
      check_val("reset_out_data", Out_Data, 0);
      check_val("reset_out_last", Out_Last, 0);
      check_val("reset_out_converged", Out_Converged, 0);
      check_val("reset_busy", Busy, 0);
      check_val("reset_overrun", Overrun, 0);
      Reset = 1'b0;

      run_frame(10, -1, 9, 64'h0123456789ABCDEF, 0, -1, -1);
      run_frame(6, 3, 3, 64'h00000000000000FF, 0, -1, -1);
      run_frame(5, -1, -1, 64'h0, 1, -1, -1);
      for (int r = 0; r < 6; r++) begin
         n = int'($urandom_range(12, 1));
         c = ($urandom_range(1, 0) != 0) ? int'($urandom_range(n - 1, 0)) : -1;
         run_frame(n, c, -1, 64'h0, 2, -1, -1);
      end
      run_frame(7, -1, -1, 64'h0, 2, 3, -1);
      run_frame(3, 1, -1, 64'h0, 0, -1, -1);
      run_frame(8, -1, -1, 64'h0, 1, -1, 5);
      run_frame(4, 0, -1, 64'h0, 2, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
